// File: rtl/dot_operand_feeder_if.sv
// Bundle of the bank write port, run command, dot_unit link and result channel of dot_operand_feeder.
// slave is the feeder's view; master is the host/dot_unit side.
interface dot_operand_feeder_if #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 6
);
  logic             wr_en;
  logic             wr_sel;
  logic [LEN_W-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             wr_drop;
  logic             cmd_valid;
  logic [LEN_W-1:0] cmd_length;
  logic             cmd_ready;
  logic             du_start;
  logic [WIDTH-1:0] du_a;
  logic [WIDTH-1:0] du_b;
  logic [LEN_W-1:0] du_length;
  logic             du_ready;
  logic             du_done;
  logic [WIDTH-1:0] du_result;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             res_err;
  logic             res_ready;
  logic             busy;

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, cmd_valid, cmd_length,
           du_ready, du_done, du_result, res_ready,
    output wr_drop, cmd_ready, du_start, du_a, du_b, du_length,
           res_valid, res_data, res_err, busy
  );

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, cmd_valid, cmd_length,
           du_ready, du_done, du_result, res_ready,
    input  wr_drop, cmd_ready, du_start, du_a, du_b, du_length,
           res_valid, res_data, res_err, busy
  );
endinterface

// File: rtl/dot_operand_feeder.sv
// Holds two FP16 operand banks, streams (A[i], B[i]) pairs into dot_unit and returns its scalar result.
// Optional watchdog abort is compiled in by defining FEEDER_TIMEOUT_EN.
module dot_operand_feeder #(
  parameter int WIDTH          = 16,
  parameter int MAX_LENGTH     = 64,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int LEN_W          = $clog2(MAX_LENGTH)
) (
  input logic clk,
  input logic reset,
  dot_operand_feeder_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] RESULT = 2'd3;
  localparam logic [WIDTH-1:0] QNAN = WIDTH'(16'h7E00);

  logic [1:0]       state;
  logic [LEN_W-1:0] idx;
  logic [LEN_W-1:0] len;
  logic [WIDTH-1:0] bank_a [MAX_LENGTH];
  logic [WIDTH-1:0] bank_b [MAX_LENGTH];
  logic [WIDTH-1:0] du_a;
  logic [WIDTH-1:0] du_b;
  logic [WIDTH-1:0] res_data;
  logic [WIDTH-1:0] first_a;
  logic [WIDTH-1:0] first_b;
  logic             du_start;
  logic             res_valid;
  logic             cmd_ready;
  logic             wr_drop;
  logic             wr_ok;
  logic             accept;
  logic             advance;
  logic             abort;
  logic             res_err;

  assign wr_ok   = bus.wr_en && (state == IDLE || state == RESULT);
  assign accept  = bus.cmd_valid && cmd_ready;
  assign advance = (state == STREAM) && bus.du_ready && (idx < len);

  // Element 0 is fetched on the same edge a write may land on it, so forward the write data.
  assign first_a = (wr_ok && !bus.wr_sel && bus.wr_addr == '0) ? bus.wr_data : bank_a[0];
  assign first_b = (wr_ok &&  bus.wr_sel && bus.wr_addr == '0) ? bus.wr_data : bank_b[0];

  // Operand banks carry no reset so their contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (wr_ok && !bus.wr_sel) bank_a[bus.wr_addr] <= bus.wr_data;
    if (wr_ok &&  bus.wr_sel) bank_b[bus.wr_addr] <= bus.wr_data;
  end

  // Sequencer: accept a run, feed pairs as dot_unit consumes them, then hold the result for the consumer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      len       <= '0;
      du_a      <= '0;
      du_b      <= '0;
      du_start  <= 1'b0;
      res_data  <= '0;
      res_valid <= 1'b0;
      cmd_ready <= 1'b0;
      wr_drop   <= 1'b0;
    end else begin
      wr_drop <= bus.wr_en && (state == STREAM || state == WAIT);
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            len       <= bus.cmd_length;
            cmd_ready <= 1'b0;
            if (bus.cmd_length == '0) begin
              res_data  <= '0;
              res_valid <= 1'b1;
              state     <= RESULT;
            end else begin
              du_a     <= first_a;
              du_b     <= first_b;
              du_start <= 1'b1;
              idx      <= LEN_W'(1);
              state    <= (bus.cmd_length == LEN_W'(1)) ? WAIT : STREAM;
            end
          end
        end
        STREAM, WAIT: begin
          if (bus.du_done) begin
            res_data  <= bus.du_result;
            res_valid <= 1'b1;
            du_start  <= 1'b0;
            state     <= RESULT;
          end else if (abort) begin
            res_data  <= QNAN;
            res_valid <= 1'b1;
            du_start  <= 1'b0;
            state     <= RESULT;
          end else if (advance) begin
            du_a <= bank_a[idx];
            du_b <= bank_b[idx];
            idx  <= idx + LEN_W'(1);
            if (idx + LEN_W'(1) == len) state <= WAIT;
          end
        end
        default: begin
          if (bus.res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef FEEDER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd;

  // Watchdog restarts whenever dot_unit shows progress; expiry forces a NaN error result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd      <= '0;
      res_err <= 1'b0;
    end else begin
      if ((state != STREAM && state != WAIT) || advance || bus.du_done) wd <= '0;
      else wd <= wd + WD_W'(1);
      if (abort) res_err <= 1'b1;
      else if (state == RESULT && bus.res_ready) res_err <= 1'b0;
    end
  end

  assign abort = (state == STREAM || state == WAIT) && !bus.du_done
                 && (wd == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign abort   = 1'b0;
  assign res_err = 1'b0;
`endif

  assign bus.wr_drop   = wr_drop;
  assign bus.cmd_ready = cmd_ready;
  assign bus.du_start  = du_start;
  assign bus.du_a      = du_a;
  assign bus.du_b      = du_b;
  assign bus.du_length = len;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_data;
  assign bus.res_err   = res_err;
  assign bus.busy      = (state == STREAM) || (state == WAIT);

endmodule

// File: tb/tb_dot_operand_feeder.sv
// Directed self-checking bench for dot_operand_feeder with a behavioural dot_unit stand-in.
// Define FEEDER_TIMEOUT_EN on both files to also exercise the watchdog abort.
module tb_dot_operand_feeder;
  localparam int WIDTH = 16;
  localparam int LEN_W = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;

  dot_operand_feeder_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

  dot_operand_feeder #(
    .WIDTH(WIDTH), .MAX_LENGTH(64), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount = 0;

  logic        modelEnable = 1'b0;
  logic        neverDone = 1'b0;
  int          stallLeft = 0;
  int          consumed = 0;
  logic        doneSent = 1'b0;
  logic        seenStart = 1'b0;
  int          startGap = 0;
  int          stallBad = 0;
  logic [15:0] modelResult = 16'h0;
  logic [15:0] stallExpA = 16'h0;
  logic [15:0] stallExpB = 16'h0;
  logic [15:0] recA [64];
  logic [15:0] recB [64];
  logic [15:0] vecA [4] = '{16'h4000, 16'h3C00, 16'h4200, 16'h4400};
  logic [15:0] vecB [4] = '{16'h4000, 16'h3C00, 16'h4000, 16'h3C00};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // dot_unit stand-in: consumes one pair per negedge-raised du_ready, optional initial stall, then one done pulse.
  always @(negedge clk) begin
    bus.du_done = 1'b0;
    if (!reset || !modelEnable) begin
      bus.du_ready = 1'b0;
    end else begin
      if (bus.du_start) seenStart = 1'b1;
      if (seenStart && !doneSent && !bus.du_start) startGap++;
      if (!bus.du_start) begin
        bus.du_ready = 1'b0;
      end else if (consumed == int'(bus.du_length)) begin
        bus.du_ready = 1'b0;
        if (!doneSent && !neverDone) begin
          bus.du_done   = 1'b1;
          bus.du_result = modelResult;
          doneSent      = 1'b1;
        end
      end else if (consumed == 0 && stallLeft > 0) begin
        bus.du_ready = 1'b0;
        stallLeft--;
        if (bus.du_a !== stallExpA || bus.du_b !== stallExpB) stallBad++;
      end else begin
        bus.du_ready = 1'b1;
        recA[consumed] = bus.du_a;
        recB[consumed] = bus.du_b;
        consumed++;
      end
    end
  end

  task automatic resetModel(input int stall, input logic [15:0] result);
    modelEnable = 1'b1;
    neverDone   = 1'b0;
    stallLeft   = stall;
    consumed    = 0;
    doneSent    = 1'b0;
    seenStart   = 1'b0;
    startGap    = 0;
    stallBad    = 0;
    modelResult = result;
  endtask

  task automatic applyStimulus(input logic we, input logic sel, input logic [5:0] addr,
                               input logic [15:0] data, input logic cv, input logic [5:0] len);
    bus.wr_en      = we;
    bus.wr_sel     = sel;
    bus.wr_addr    = addr;
    bus.wr_data    = data;
    bus.cmd_valid  = cv;
    bus.cmd_length = len;
    @(posedge clk); #1;
    bus.wr_en     = 1'b0;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic waitResult(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (!bus.res_valid && cycles < budget) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput({tag, "_res_valid"}, bus.res_valid, 1);
  endtask

  task automatic handshake(input string tag);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    checkOutput({tag, "_res_valid_cleared"}, bus.res_valid, 0);
  endtask

  initial begin
    int cyc;
    bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.cmd_valid = 1'b0; bus.cmd_length = '0; bus.res_ready = 1'b0;
    bus.du_ready = 1'b0; bus.du_done = 1'b0; bus.du_result = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cmd_ready", bus.cmd_ready, 0);
    checkOutput("rst_du_start", bus.du_start, 0);
    checkOutput("rst_res_valid", bus.res_valid, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_wr_drop", bus.wr_drop, 0);
    checkOutput("rst_du_length", bus.du_length, 0);
    checkOutput("rst_res_data", bus.res_data, 0);
    checkOutput("rst_res_err", bus.res_err, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle_cmd_ready", bus.cmd_ready, 1);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 6'(i), vecA[i], 1'b0, 6'd0);
      applyStimulus(1'b1, 1'b1, 6'(i), vecB[i], 1'b0, 6'd0);
    end
    checkOutput("idle_write_no_drop", bus.wr_drop, 0);

    $display("[TB] basic 4-element run");
    resetModel(0, 16'h4B80);
    applyStimulus(1'b0, 1'b0, 6'd0, 16'h0, 1'b1, 6'd4);
    checkOutput("t1_du_start", bus.du_start, 1);
    checkOutput("t1_du_length", bus.du_length, 4);
    checkOutput("t1_du_a0", bus.du_a, 16'h4000);
    checkOutput("t1_busy", bus.busy, 1);
    checkOutput("t1_cmd_ready", bus.cmd_ready, 0);
    waitResult("t1", 60, cyc);
    checkOutput("t1_res_data", bus.res_data, 16'h4B80);
    checkOutput("t1_res_err", bus.res_err, 0);
    checkOutput("t1_du_start_low", bus.du_start, 0);
    checkOutput("t1_pairs", consumed, 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t1_a%0d", i), recA[i], vecA[i]);
      checkOutput($sformatf("t1_b%0d", i), recB[i], vecB[i]);
    end
    handshake("t1");
    checkOutput("t1_back_idle", bus.cmd_ready, 1);

    $display("[TB] stalled element 0");
    resetModel(5, 16'h4B80);
    stallExpA = 16'h4000;
    stallExpB = 16'h4000;
    applyStimulus(1'b0, 1'b0, 6'd0, 16'h0, 1'b1, 6'd4);
    waitResult("t2", 60, cyc);
    checkOutput("t2_stall_stable", stallBad, 0);
    checkOutput("t2_stall_used", stallLeft, 0);
    checkOutput("t2_start_gap", startGap, 0);
    checkOutput("t2_pairs", consumed, 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t2_a%0d", i), recA[i], vecA[i]);
      checkOutput($sformatf("t2_b%0d", i), recB[i], vecB[i]);
    end
    handshake("t2");

    $display("[TB] zero-length command");
    resetModel(0, 16'hFFFF);
    applyStimulus(1'b0, 1'b0, 6'd0, 16'h0, 1'b1, 6'd0);
    checkOutput("t3_res_valid", bus.res_valid, 1);
    checkOutput("t3_res_data", bus.res_data, 0);
    checkOutput("t3_du_start", bus.du_start, 0);
    checkOutput("t3_cmd_ready", bus.cmd_ready, 0);
    applyStimulus(1'b0, 1'b0, 6'd0, 16'h0, 1'b0, 6'd0);
    checkOutput("t3_never_started", seenStart, 0);
    handshake("t3");

    $display("[TB] result backpressure");
    resetModel(0, 16'h5555);
    applyStimulus(1'b0, 1'b0, 6'd0, 16'h0, 1'b1, 6'd4);
    waitResult("t4", 60, cyc);
    bus.cmd_valid  = 1'b1;
    bus.cmd_length = 6'd0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("t4_hold_data%0d", i), bus.res_data, 16'h5555);
      checkOutput($sformatf("t4_hold_cmd_ready%0d", i), bus.cmd_ready, 0);
    end
    checkOutput("t4_hold_valid", bus.res_valid, 1);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    checkOutput("t4_handshake_valid", bus.res_valid, 0);
    checkOutput("t4_handshake_cmd_ready", bus.cmd_ready, 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    checkOutput("t4_pending_accepted", bus.res_valid, 1);
    checkOutput("t4_pending_data", bus.res_data, 0);
    handshake("t4");

    $display("[TB] write during stream");
    resetModel(5, 16'h4B80);
    applyStimulus(1'b0, 1'b0, 6'd0, 16'h0, 1'b1, 6'd4);
    applyStimulus(1'b1, 1'b0, 6'd1, 16'hBEEF, 1'b0, 6'd0);
    checkOutput("t5_wr_drop", bus.wr_drop, 1);
    applyStimulus(1'b0, 1'b0, 6'd0, 16'h0, 1'b0, 6'd0);
    checkOutput("t5_wr_drop_pulse", bus.wr_drop, 0);
    waitResult("t5", 60, cyc);
    handshake("t5");
    resetModel(0, 16'h0001);
    applyStimulus(1'b1, 1'b0, 6'd0, 16'h4200, 1'b1, 6'd4);
    checkOutput("t5_bypass_du_a0", bus.du_a, 16'h4200);
    waitResult("t5b", 60, cyc);
    checkOutput("t5_bypass_a0", recA[0], 16'h4200);
    checkOutput("t5_a1_unchanged", recA[1], 16'h3C00);
    checkOutput("t5b_res_data", bus.res_data, 16'h0001);
    handshake("t5b");

    $display("[TB] reset mid-stream");
    resetModel(10, 16'h0);
    stallExpA = 16'h4200;
    applyStimulus(1'b0, 1'b0, 6'd0, 16'h0, 1'b1, 6'd4);
    applyStimulus(1'b0, 1'b0, 6'd0, 16'h0, 1'b0, 6'd0);
    checkOutput("t6_busy_before", bus.busy, 1);
    reset = 1'b0;
    #1;
    checkOutput("t6_du_start", bus.du_start, 0);
    checkOutput("t6_busy", bus.busy, 0);
    checkOutput("t6_res_valid", bus.res_valid, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    modelEnable = 1'b0;
    @(posedge clk); #1;
    checkOutput("t6_idle_cmd_ready", bus.cmd_ready, 1);
    checkOutput("t6_idle_busy", bus.busy, 0);

`ifdef FEEDER_TIMEOUT_EN
    $display("[TB] watchdog abort");
    resetModel(0, 16'h0);
    neverDone = 1'b1;
    applyStimulus(1'b0, 1'b0, 6'd0, 16'h0, 1'b1, 6'd4);
    waitResult("t7", 80, cyc);
    checkOutput("t7_latency", cyc, 19);
    checkOutput("t7_res_data", bus.res_data, 16'h7E00);
    checkOutput("t7_res_err", bus.res_err, 1);
    checkOutput("t7_du_start", bus.du_start, 0);
    handshake("t7");
    checkOutput("t7_res_err_cleared", bus.res_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
